// File: rtl/syndrome_calc_if.sv
// Symbol input and syndrome output bundle for the GF(2^5) syndrome calculator.
// The bench drives through the master modport and the design sits on the slave modport.
interface syndrome_calc_if;
    logic [4:0] datain;
    logic       data_valid;
    logic       start;
    logic [4:0] syn1;
    logic [4:0] syn2;
    logic [4:0] syn3;
    logic [4:0] syn4;
    logic       syn_valid;
    logic       no_error;
    logic       busy;

    modport master (
        output datain, data_valid, start,
        input  syn1, syn2, syn3, syn4, syn_valid, no_error, busy
    );

    modport slave (
        input  datain, data_valid, start,
        output syn1, syn2, syn3, syn4, syn_valid, no_error, busy
    );
endinterface

// File: rtl/syndrome_calc.sv
// Computes S1..S4 = r(alpha^j) for a 31-symbol codeword over GF(2^5), p(x)=x^5+x^2+1.
// Symbols arrive highest degree first and are folded in by Horner's rule.
module syndrome_calc #(
    parameter int NSYM = 31
) (
    input  logic           clock,
    input  logic           reset,
    syndrome_calc_if.slave bus
);
    localparam int DATA_W = 5;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Multiply by alpha: shift left, fold x^5 back in as x^2+1.
    function automatic logic [DATA_W-1:0] gf_mul_a1(input logic [DATA_W-1:0] a);
        return {a[3], a[2], a[1] ^ a[4], a[0], a[4]};
    endfunction

    function automatic logic [DATA_W-1:0] gf_mul_a2(input logic [DATA_W-1:0] a);
        return gf_mul_a1(gf_mul_a1(a));
    endfunction

    function automatic logic [DATA_W-1:0] gf_mul_a3(input logic [DATA_W-1:0] a);
        return gf_mul_a1(gf_mul_a2(a));
    endfunction

    function automatic logic [DATA_W-1:0] gf_mul_a4(input logic [DATA_W-1:0] a);
        return gf_mul_a2(gf_mul_a2(a));
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        count_q, count_d;
    logic [DATA_W-1:0] acc1_q, acc2_q, acc3_q, acc4_q;
    logic [DATA_W-1:0] acc1_d, acc2_d, acc3_d, acc4_d;
    logic [DATA_W-1:0] syn1_q, syn2_q, syn3_q, syn4_q;
    logic [DATA_W-1:0] syn1_d, syn2_d, syn3_d, syn4_d;
    logic              syn_valid_q, syn_valid_d;
    logic              no_error_q, no_error_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] nxt1, nxt2, nxt3, nxt4;

    always_comb begin
        nxt1 = gf_mul_a1(acc1_q) ^ bus.datain;
        nxt2 = gf_mul_a2(acc2_q) ^ bus.datain;
        nxt3 = gf_mul_a3(acc3_q) ^ bus.datain;
        nxt4 = gf_mul_a4(acc4_q) ^ bus.datain;

        state_d     = state_q;
        count_d     = count_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        acc3_d      = acc3_q;
        acc4_d      = acc4_q;
        syn1_d      = syn1_q;
        syn2_d      = syn2_q;
        syn3_d      = syn3_q;
        syn4_d      = syn4_q;
        no_error_d  = no_error_q;
        syn_valid_d = 1'b0;

        // A start always (re)opens a codeword, abandoning any partial one.
        if (bus.data_valid && bus.start) begin
            state_d = ACCUM;
            count_d = 5'd1;
            acc1_d  = bus.datain;
            acc2_d  = bus.datain;
            acc3_d  = bus.datain;
            acc4_d  = bus.datain;
        end else if (state_q == ACCUM && bus.data_valid) begin
            acc1_d = nxt1;
            acc2_d = nxt2;
            acc3_d = nxt3;
            acc4_d = nxt4;
            if (count_q == 5'(NSYM - 1)) begin
                state_d     = IDLE;
                count_d     = 5'd0;
                syn1_d      = nxt1;
                syn2_d      = nxt2;
                syn3_d      = nxt3;
                syn4_d      = nxt4;
                no_error_d  = ~(|{nxt1, nxt2, nxt3, nxt4});
                syn_valid_d = 1'b1;
            end else begin
                count_d = count_q + 5'd1;
            end
        end

        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            acc3_q      <= '0;
            acc4_q      <= '0;
            syn1_q      <= '0;
            syn2_q      <= '0;
            syn3_q      <= '0;
            syn4_q      <= '0;
            syn_valid_q <= 1'b0;
            no_error_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            acc3_q      <= acc3_d;
            acc4_q      <= acc4_d;
            syn1_q      <= syn1_d;
            syn2_q      <= syn2_d;
            syn3_q      <= syn3_d;
            syn4_q      <= syn4_d;
            syn_valid_q <= syn_valid_d;
            no_error_q  <= no_error_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.syn1      = syn1_q;
    assign bus.syn2      = syn2_q;
    assign bus.syn3      = syn3_q;
    assign bus.syn4      = syn4_q;
    assign bus.syn_valid = syn_valid_q;
    assign bus.no_error  = no_error_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/syndrome_calc.md
SYNDROME_CALC -- requirements
Module: syndrome_calc

Interface
REQ-001 Parameter: NSYM, default 31, codeword length in symbols; only 31 is supported.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: datain  input  5  received symbol, bit 4 MSB, polynomial basis over GF(2^5), p(x)=x^5+x^2+1.
REQ-005 Port: data_valid  input  1  datain is accepted on this clock edge.
REQ-006 Port: start  input  1  qualified by data_valid; marks the first symbol (r30, highest degree) of a codeword.
REQ-007 Ports: syn1, syn2, syn3, syn4  output  5 each  held syndromes S_j = r(alpha^j), alpha = 5'b00010.
REQ-008 Port: syn_valid  output  1  one-cycle pulse when syn1..syn4 update.
REQ-009 Port: no_error  output  1  high when all four held syndromes are zero.
REQ-010 Port: busy  output  1  high while a codeword is being accumulated.

Function
REQ-011 State machine: IDLE, ACCUM; the state register is reset to IDLE.
REQ-012 IDLE with data_valid=0 or start=0 -> stay IDLE, ignore the input.
REQ-013 IDLE with data_valid=1 and start=1 -> ACCUM; accumulator A_j <= datain for j=1..4; symbol count <= 1.
REQ-014 ACCUM with data_valid=1 and start=0 -> A_j <= A_j*alpha^j + datain (Horner); count increments.
REQ-015 ACCUM with data_valid=0 -> accumulators and count hold; gaps of any length are allowed.
REQ-016 ACCUM with data_valid=1 and start=1 -> abandon the current codeword and restart exactly as REQ-013; no syn_valid for the abandoned codeword.
REQ-017 Completion: the update that accepts symbol NSYM (count becomes 31) writes the final A_j values to syn1..syn4, pulses syn_valid on the next cycle, and returns to IDLE.
REQ-018 Latency: syn_valid is high exactly one cycle, on the cycle immediately after the 31st accepted symbol edge.
REQ-019 The cycle after completion, data_valid=1 with start=1 opens a new codeword; back-to-back codewords have no dead cycle.
REQ-020 syn1..syn4 and no_error hold their values until the next completion.
REQ-021 no_error is registered together with syn1..syn4 (same edge) as the NOR of all 20 syndrome bits.
REQ-022 Constant multiplies by alpha^1..alpha^4 are fixed XOR networks reduced mod x^5+x^2+1; GF addition is bitwise XOR; all widths are exactly 5 bits.
REQ-023 The 5-bit count never exceeds 31; it is cleared on entry to IDLE.
REQ-024 busy = 1 exactly when state is ACCUM.

Reset
REQ-025 A reset high at a clock edge forces state=IDLE, count=0, A_j=0, syn1..syn4=0, syn_valid=0, busy=0, no_error=1.
REQ-026 Reset takes priority over data_valid/start on the same edge.
REQ-027 Reset mid-codeword discards the partial codeword; the discarded codeword produces no syn_valid.

Verification
REQ-028 31 zero symbols, start on the first -> one syn_valid pulse; syn1..syn4=00000; no_error=1.
REQ-029 30 zeros then r0=00001 -> syn1..syn4 all = 00001; no_error=0.
REQ-030 r30=00001 (first symbol) then 30 zeros -> syn1=10010, syn2=01001, syn3=10110, syn4=01011.
REQ-031 Repeat the REQ-030 stream with random data_valid gaps of 0-5 cycles -> identical syndromes; syn_valid pulses once, one cycle after the last symbol.
REQ-032 Assert reset after 15 symbols, then send the REQ-029 stream -> REQ-029 result; no syn_valid from the aborted codeword.
REQ-033 Issue start after 10 symbols of a garbage codeword, then a full REQ-030 stream -> REQ-030 result only; exactly one syn_valid.
